// File: rtl/demux_stream_pkg.sv
// Shared types and constants for the N-channel streaming demultiplexer.
package demux_stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } demux_lock_e;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/demux_stream_n_if.sv
// Stream bundle of the demultiplexer: one producer side, N consumer sides, drop status.
interface demux_stream_n_if import demux_stream_pkg::*; #(
    parameter int W = 8,
    parameter int N = 4
);
    localparam int SW = $clog2(N);

    logic [W-1:0]          in_data;
    logic [SW-1:0]         in_sel;
    logic                  in_last;
    logic                  in_valid;
    logic                  in_ready;
    logic [N*W-1:0]        out_data;
    logic [N-1:0]          out_valid;
    logic [N-1:0]          out_ready;
    logic                  err;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output in_data, in_sel, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err, drop_cnt
    );

    modport slave (
        input  in_data, in_sel, in_last, in_valid, out_ready,
        output in_ready, out_data, out_valid, err, drop_cnt
    );

endinterface

// File: rtl/demux_out_reg.sv
// One-entry output register for a single channel; a load wins over a same-cycle drain.
module demux_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_r;
    logic [W-1:0] q_r;

    // Entry state: load, drain or hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            q_r     <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            q_r     <= data;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
            q_r     <= q_r;
        end else begin
            valid_r <= valid_r;
            q_r     <= q_r;
        end
    end

    assign valid = valid_r;
    assign q     = q_r;

endmodule

// File: rtl/demux_stream_n.sv
// N-channel W-bit streaming demultiplexer with out-of-range drop counting.
// Optional packet-lock FSM enabled by defining DEMUX_PKT_LOCK_EN.
module demux_stream_n import demux_stream_pkg::*; #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input logic              clk,
    input logic              rst_n,
    demux_stream_n_if.slave  bus
);

    logic [SW-1:0]         esel_s;
    logic                  sel_ok_s;
    logic [N-1:0]          hit_s;
    logic [N-1:0]          load_s;
    logic                  busy_s;
    logic                  accept_s;
    logic                  drop_s;
    logic                  err_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;
    logic                  ch_valid_s [N];
    logic [W-1:0]          ch_data_s  [N];

`ifdef DEMUX_PKT_LOCK_EN
    demux_lock_e   state_r;
    logic [SW-1:0] lock_sel_r;

    // Effective select: latched channel while a packet is in flight
    always_comb begin
        if (state_r == LOCKED) begin
            esel_s = lock_sel_r;
        end else begin
            esel_s = bus.in_sel;
        end
    end

    // Packet lock FSM; an out-of-range first beat never locks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            lock_sel_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && sel_ok_s && !bus.in_last) begin
                        state_r    <= LOCKED;
                        lock_sel_r <= esel_s;
                    end else begin
                        state_r    <= IDLE;
                        lock_sel_r <= lock_sel_r;
                    end
                end
                LOCKED: begin
                    if (accept_s && bus.in_last) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= LOCKED;
                    end
                    lock_sel_r <= lock_sel_r;
                end
                default: begin
                    state_r    <= IDLE;
                    lock_sel_r <= '0;
                end
            endcase
        end
    end
`else
    logic unused_last_s;

    assign esel_s        = bus.in_sel;
    assign unused_last_s = bus.in_last;
`endif

    assign sel_ok_s = 32'(esel_s) < N;

    // One-hot destination decode; empty for an out-of-range select
    always_comb begin
        hit_s = '0;
        for (int k = 0; k < N; k++) begin
            hit_s[k] = sel_ok_s && (esel_s == SW'(k));
        end
    end

    assign busy_s       = |(hit_s & bus.out_valid & ~bus.out_ready);
    assign bus.in_ready = rst_n && (!sel_ok_s || !busy_s);
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign load_s       = hit_s & {N{accept_s}};
    assign drop_s       = accept_s && !sel_ok_s;

    // Drop pulse and saturating drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r      <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            err_r <= drop_s;
            if (drop_s && (drop_cnt_r != DROP_CNT_MAX)) begin
                drop_cnt_r <= drop_cnt_r + 1'b1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_ch
        demux_out_reg #(.W(W)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_s[k]),
            .data  (bus.in_data),
            .ready (bus.out_ready[k]),
            .valid (ch_valid_s[k]),
            .q     (ch_data_s[k])
        );
    end

    // Pack per-channel registers onto the bus
    always_comb begin
        bus.out_valid = '0;
        bus.out_data  = '0;
        for (int k = 0; k < N; k++) begin
            bus.out_valid[k]         = ch_valid_s[k];
            bus.out_data[k*W +: W]   = ch_data_s[k];
        end
    end

    assign bus.err      = err_r;
    assign bus.drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_demux_stream_n.sv
// Scoreboard bench for demux_stream_n: N=4 routing/backpressure/lock, N=3 drop counting.
module tb_demux_stream_n;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    logic [7:0] exp_q [4][$];

    demux_stream_n_if #(.W(8), .N(4)) b4 ();
    demux_stream_n_if #(.W(8), .N(3)) b3 ();

    demux_stream_n #(.W(8), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    demux_stream_n #(.W(8), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Monitor: pop the channel queue whenever a beat is consumed
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (b4.out_valid[k] && b4.out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mon_unexpected_ch%0d actual=%02h expected=none", k, b4.out_data[k*8 +: 8]);
                    end else begin
                        check($sformatf("mon_ch%0d", k), {24'd0, b4.out_data[k*8 +: 8]}, {24'd0, exp_q[k].pop_front()});
                    end
                end
            end
            check("mon_err4", {31'd0, b4.err}, 32'd0);
            check("mon_valid3", {29'd0, b3.out_valid}, 32'd0);
        end
    end

    task automatic send4(input logic [7:0] d, input logic [1:0] s, input logic l, input int ch);
        int waited;
        waited = 0;
        b4.in_data  = d;
        b4.in_sel   = s;
        b4.in_last  = l;
        b4.in_valid = 1'b1;
        @(negedge clk);
        while (!b4.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!b4.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low expected=accept data=%02h", d);
            b4.in_valid = 1'b0;
        end else begin
            exp_q[ch].push_back(d);
            @(posedge clk);
            #1;
            b4.in_valid = 1'b0;
            check("lat_valid", {31'd0, b4.out_valid[ch]}, 32'd1);
            check("lat_data", {24'd0, b4.out_data[ch*8 +: 8]}, {24'd0, d});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int c0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        b4.in_data = 8'hFF; b4.in_sel = 2'd0; b4.in_last = 1'b0; b4.in_valid = 1'b1; b4.out_ready = 4'hF;
        b3.in_data = 8'hEE; b3.in_sel = 2'd3; b3.in_last = 1'b0; b3.in_valid = 1'b1; b3.out_ready = 3'h7;

        // Reset held 3 cycles with valid input
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_in_ready4", {31'd0, b4.in_ready}, 32'd0);
            check("rst_in_ready3", {31'd0, b3.in_ready}, 32'd0);
            check("rst_valid4", {28'd0, b4.out_valid}, 32'd0);
            check("rst_data4", b4.out_data, 32'd0);
            check("rst_drop3", {24'd0, b3.drop_cnt}, 32'd0);
            check("rst_err3", {31'd0, b3.err}, 32'd0);
        end
        b4.in_valid = 1'b0;
        b3.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Routing, 4 beats in 4 cycles
        c0 = cyc;
        send4(8'hA1, 2'd0, 1'b1, 0);
        send4(8'hB2, 2'd1, 1'b1, 1);
        send4(8'hC3, 2'd2, 1'b1, 2);
        send4(8'hD4, 2'd3, 1'b1, 3);
        check("throughput_cycles", cyc - c0, 32'd4);

        // Backpressure on channel 2
        b4.out_ready[2] = 1'b0;
        send4(8'h11, 2'd2, 1'b1, 2);
        b4.in_data = 8'h22; b4.in_sel = 2'd2; b4.in_last = 1'b1; b4.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, b4.in_ready}, 32'd0);
            check("bp_hold_valid", {31'd0, b4.out_valid[2]}, 32'd1);
            check("bp_hold_data", {24'd0, b4.out_data[23:16]}, 32'h11);
        end
        @(posedge clk);
        #1;
        b4.out_ready[2] = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, b4.in_ready}, 32'd1);
        exp_q[2].push_back(8'h22);
        @(posedge clk);
        #1;
        b4.in_valid = 1'b0;
        check("bp_swap_valid", {31'd0, b4.out_valid[2]}, 32'd1);
        check("bp_swap_data", {24'd0, b4.out_data[23:16]}, 32'h22);

`ifdef DEMUX_PKT_LOCK_EN
        // Packet lock: whole packet follows the first beat's select
        send4(8'hE1, 2'd1, 1'b0, 1);
        send4(8'hE2, 2'd3, 1'b0, 1);
        send4(8'hE3, 2'd0, 1'b1, 1);
        send4(8'hE4, 2'd0, 1'b1, 0);
`else
        // in_last ignored: every beat routes on its own select
        send4(8'hE1, 2'd1, 1'b0, 1);
        send4(8'hE2, 2'd3, 1'b0, 3);
        send4(8'hE3, 2'd0, 1'b1, 0);
`endif

        // Reset while a beat is stalled discards it
        b4.out_ready[1] = 1'b0;
        send4(8'h77, 2'd1, 1'b1, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_stall_in_ready", {31'd0, b4.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_stall_valid", {28'd0, b4.out_valid}, 32'd0);
        exp_q[1].delete();
        b4.out_ready[1] = 1'b1;
        rst_n = 1'b1;

        // Out-of-range drops on the N=3 instance
        check("drop_cnt_start", {24'd0, b3.drop_cnt}, 32'd0);
        b3.in_sel = 2'd3; b3.in_data = 8'h5A; b3.in_valid = 1'b1;
        for (int i = 0; i < 301; i++) begin
            @(negedge clk);
            check("drop_in_ready", {31'd0, b3.in_ready}, 32'd1);
            @(posedge clk);
            #1;
            check("drop_err", {31'd0, b3.err}, 32'd1);
            check("drop_cnt", {24'd0, b3.drop_cnt}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end
        b3.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drop_err_clear", {31'd0, b3.err}, 32'd0);
        check("drop_cnt_sat", {24'd0, b3.drop_cnt}, 32'd255);

`ifdef DEMUX_PKT_LOCK_EN
        // Reset mid-packet returns the lock to IDLE
        send4(8'h51, 2'd2, 1'b0, 2);
        send4(8'h52, 2'd0, 1'b0, 2);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send4(8'h53, 2'd3, 1'b1, 3);
`endif

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_empty_ch%0d", k), exp_q[k].size(), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
